// File: rtl/rob_multi_retire_if.sv
// Bundle of dispatch, writeback, branch-resolution and retire signals
// exchanged between the reorder buffer and the rest of the core.
interface rob_multi_retire_if #(
    parameter int DEPTH    = 32,
    parameter int TAG_W    = $clog2(DEPTH),
    parameter int PREG_W   = 7,
    parameter int NUM_WB   = 3,
    parameter int RETIRE_W = 2
);
    logic                       alloc_valid;
    logic                       alloc_ready;
    logic [TAG_W-1:0]           alloc_tag;
    logic                       alloc_has_rd;
    logic [PREG_W-1:0]          alloc_pd_new;
    logic [PREG_W-1:0]          alloc_pd_old;
    logic [31:0]                alloc_pc;
    logic [NUM_WB-1:0]          wb_valid;
    logic [NUM_WB*TAG_W-1:0]    wb_tag;
    logic                       br_mispredict;
    logic [TAG_W-1:0]           br_tag;
    logic                       flush_out;
    logic [TAG_W-1:0]           flush_tag;
    logic [RETIRE_W-1:0]        retire_valid;
    logic [RETIRE_W-1:0]        retire_has_rd;
    logic [RETIRE_W*PREG_W-1:0] retire_pd_old;
    logic [RETIRE_W*32-1:0]     retire_pc;
    logic [TAG_W-1:0]           head;
    logic [TAG_W:0]             count;

    // Core side: dispatch, functional units and branch unit
    modport master (
        output alloc_valid, alloc_has_rd, alloc_pd_new, alloc_pd_old, alloc_pc,
        output wb_valid, wb_tag, br_mispredict, br_tag,
        input  alloc_ready, alloc_tag, flush_out, flush_tag,
        input  retire_valid, retire_has_rd, retire_pd_old, retire_pc, head, count
    );

    // Reorder buffer side
    modport slave (
        input  alloc_valid, alloc_has_rd, alloc_pd_new, alloc_pd_old, alloc_pc,
        input  wb_valid, wb_tag, br_mispredict, br_tag,
        output alloc_ready, alloc_tag, flush_out, flush_tag,
        output retire_valid, retire_has_rd, retire_pd_old, retire_pc, head, count
    );
endinterface

// File: rtl/rob_multi_retire.sv
// Reorder buffer with multiple writeback ports, up to RETIRE_W in-order
// retirements per cycle and squash of entries younger than a mispredicted
// branch. Entry ages are measured from head so wrap-around is transparent.
module rob_multi_retire #(
    parameter int DEPTH    = 32,
    parameter int TAG_W    = $clog2(DEPTH),
    parameter int PREG_W   = 7,
    parameter int NUM_WB   = 3,
    parameter int RETIRE_W = 2
) (
    input logic               clk,
    input logic               reset,
    rob_multi_retire_if.slave rob
);
    localparam int CNT_W  = TAG_W + 1;
    localparam int RCNT_W = $clog2(RETIRE_W + 1);
    localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);

    logic [TAG_W-1:0]  head_reg, head_next;
    logic [TAG_W-1:0]  tail_reg, tail_next;
    logic [CNT_W-1:0]  count_reg, count_next;
    logic [DEPTH-1:0]  valid_reg, valid_next;
    logic [DEPTH-1:0]  done_reg, done_next;
    logic              flush_out_reg;
    logic [TAG_W-1:0]  flush_tag_reg;

    // Payload storage, written only at the tail
    logic              has_rd_mem [DEPTH];
    logic [PREG_W-1:0] pd_new_mem [DEPTH];
    logic [PREG_W-1:0] pd_old_mem [DEPTH];
    logic [31:0]       pc_mem     [DEPTH];

    logic              alloc_fire;
    logic              br_fire;
    logic [TAG_W-1:0]  br_age;
    logic [TAG_W-1:0]  slot_idx [RETIRE_W];
    logic [RETIRE_W-1:0] retire_vec;
    logic [RCNT_W-1:0] retire_cnt;
    logic [DEPTH-1:0]  retire_mask;
    logic [DEPTH-1:0]  kill_mask;
    logic [DEPTH-1:0]  wb_mask;

    assign rob.alloc_ready = (count_reg < FULL) && !rob.br_mispredict;
    assign rob.alloc_tag   = tail_reg;
    assign rob.head        = head_reg;
    assign rob.count       = count_reg;
    assign rob.flush_out   = flush_out_reg;
    assign rob.flush_tag   = flush_tag_reg;

    assign alloc_fire = rob.alloc_valid && rob.alloc_ready;
    // A mispredict naming an empty slot is stale and must not disturb state
    assign br_fire    = rob.br_mispredict && valid_reg[rob.br_tag];
    assign br_age     = rob.br_tag - head_reg;

    genvar gi;
    generate
        for (gi = 0; gi < RETIRE_W; gi++) begin : g_slot
            assign slot_idx[gi] = head_reg + TAG_W'(gi);
            assign rob.retire_has_rd[gi] = retire_vec[gi] && has_rd_mem[slot_idx[gi]];
            assign rob.retire_pd_old[gi*PREG_W +: PREG_W] = pd_old_mem[slot_idx[gi]];
            assign rob.retire_pc[gi*32 +: 32] = pc_mem[slot_idx[gi]];
        end
        // An entry is squashed when it is strictly younger than the branch
        for (gi = 0; gi < DEPTH; gi++) begin : g_entry
            logic [TAG_W-1:0] age;
            assign age = TAG_W'(gi) - head_reg;
            assign kill_mask[gi] = br_fire && (age > br_age);
        end
    endgenerate

    assign rob.retire_valid = retire_vec;

    // Contiguous retire window from head; the first not-done entry stops it
    always_comb begin
        logic chain;
        chain       = !reset;
        retire_vec  = '0;
        retire_cnt  = '0;
        retire_mask = '0;
        for (int i = 0; i < RETIRE_W; i++) begin
            chain = chain && valid_reg[slot_idx[i]] && done_reg[slot_idx[i]];
            retire_vec[i] = chain;
            if (chain) begin
                retire_mask[slot_idx[i]] = 1'b1;
                retire_cnt = retire_cnt + 1'b1;
            end
        end
    end

    // Collect completion strobes from all writeback ports (duplicates merge)
    always_comb begin
        wb_mask = '0;
        for (int p = 0; p < NUM_WB; p++) begin
            if (rob.wb_valid[p]) begin
                wb_mask[rob.wb_tag[p*TAG_W +: TAG_W]] = 1'b1;
            end
        end
    end

    // Next entry flags and pointers; a squash resets tail to just past the branch
    always_comb begin
        valid_next = valid_reg & ~retire_mask & ~kill_mask;
        done_next  = done_reg | (wb_mask & valid_reg);
        if (alloc_fire) begin
            valid_next[tail_reg] = 1'b1;
            done_next[tail_reg]  = 1'b0;
        end
        head_next = head_reg + TAG_W'(retire_cnt);
        if (br_fire) begin
            tail_next  = rob.br_tag + TAG_W'(1);
            count_next = CNT_W'(br_age) + CNT_W'(1) - CNT_W'(retire_cnt);
        end else begin
            tail_next  = tail_reg + TAG_W'(alloc_fire);
            count_next = count_reg + CNT_W'(alloc_fire) - CNT_W'(retire_cnt);
        end
    end

    // Control state register
    always_ff @(posedge clk) begin
        if (reset) begin
            head_reg      <= '0;
            tail_reg      <= '0;
            count_reg     <= '0;
            valid_reg     <= '0;
            done_reg      <= '0;
            flush_out_reg <= 1'b0;
            flush_tag_reg <= '0;
        end else begin
            head_reg      <= head_next;
            tail_reg      <= tail_next;
            count_reg     <= count_next;
            valid_reg     <= valid_next;
            done_reg      <= done_next;
            flush_out_reg <= br_fire;
            if (br_fire) begin
                flush_tag_reg <= rob.br_tag;
            end
        end
    end

    // Payload write at the allocating tail slot
    always_ff @(posedge clk) begin
        if (alloc_fire) begin
            has_rd_mem[tail_reg] <= rob.alloc_has_rd;
            pd_new_mem[tail_reg] <= rob.alloc_pd_new;
            pd_old_mem[tail_reg] <= rob.alloc_pd_old;
            pc_mem[tail_reg]     <= rob.alloc_pc;
        end
    end
endmodule

// File: tb/tb_rob_multi_retire.sv
// Directed testbench for rob_multi_retire: fill/full, out-of-order
// completion, blocked retirement, mispredict squash, wrap-around, reset.
module tb_rob_multi_retire;
    logic clk;
    logic reset;
    int   n_checks;
    int   n_fail;

    rob_multi_retire_if #(.DEPTH(32), .PREG_W(7), .NUM_WB(3), .RETIRE_W(2)) bus ();

    rob_multi_retire #(.DEPTH(32), .PREG_W(7), .NUM_WB(3), .RETIRE_W(2)) dut (
        .clk   (clk),
        .reset (reset),
        .rob   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog expired got running want finished");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        bus.alloc_valid   = 1'b0;
        bus.alloc_has_rd  = 1'b0;
        bus.alloc_pd_new  = '0;
        bus.alloc_pd_old  = '0;
        bus.alloc_pc      = '0;
        bus.wb_valid      = '0;
        bus.wb_tag        = '0;
        bus.br_mispredict = 1'b0;
        bus.br_tag        = '0;
    endtask

    task automatic do_reset();
        clear_inputs();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic set_wb(input logic [2:0] v, input logic [4:0] t0,
                          input logic [4:0] t1, input logic [4:0] t2);
        bus.wb_valid = v;
        bus.wb_tag   = {t2, t1, t0};
    endtask

    // Allocate n ops; op i gets pd_old=10+i, pc=0x1000+4*i
    task automatic alloc_n(input int n);
        for (int i = 0; i < n; i++) begin
            bus.alloc_valid  = 1'b1;
            bus.alloc_has_rd = 1'b1;
            bus.alloc_pd_old = 7'(10 + i);
            bus.alloc_pd_new = 7'(40 + i);
            bus.alloc_pc     = 32'h1000 + 32'(4 * i);
            tick();
        end
        bus.alloc_valid = 1'b0;
    endtask

    task automatic test_reset_and_fill();
        do_reset();
        n_checks++; if (bus.alloc_ready !== 1'b1) begin n_fail++; $display("FAIL rst_alloc_ready got %0b want 1", bus.alloc_ready); end
        n_checks++; if (bus.alloc_tag !== 5'd0) begin n_fail++; $display("FAIL rst_alloc_tag got %0d want 0", bus.alloc_tag); end
        n_checks++; if (bus.retire_valid !== 2'b00) begin n_fail++; $display("FAIL rst_retire_valid got %b want 00", bus.retire_valid); end
        n_checks++; if (bus.flush_out !== 1'b0 || bus.flush_tag !== 5'd0) begin n_fail++; $display("FAIL rst_flush got %0b/%0d want 0/0", bus.flush_out, bus.flush_tag); end
        n_checks++; if (bus.count !== 6'd0 || bus.head !== 5'd0) begin n_fail++; $display("FAIL rst_count_head got %0d/%0d want 0/0", bus.count, bus.head); end
        for (int i = 0; i < 32; i++) begin
            bus.alloc_valid = 1'b1;
            n_checks++; if (bus.alloc_tag !== 5'(i)) begin n_fail++; $display("FAIL fill_tag got %0d want %0d", bus.alloc_tag, i); end
            tick();
        end
        n_checks++; if (bus.count !== 6'd32) begin n_fail++; $display("FAIL full_count got %0d want 32", bus.count); end
        n_checks++; if (bus.alloc_ready !== 1'b0) begin n_fail++; $display("FAIL full_ready got %0b want 0", bus.alloc_ready); end
        tick();
        bus.alloc_valid = 1'b0;
        n_checks++; if (bus.count !== 6'd32 || bus.alloc_tag !== 5'd0) begin n_fail++; $display("FAIL full_drop got count %0d tag %0d want 32/0", bus.count, bus.alloc_tag); end
        $display("test_reset_and_fill: done, %0d failures so far", n_fail);
    endtask

    task automatic test_ooo_complete();
        do_reset();
        alloc_n(4);
        set_wb(3'b111, 5'd3, 5'd2, 5'd1);
        n_checks++; if (bus.retire_valid !== 2'b00) begin n_fail++; $display("FAIL ooo_wb_cycle got %b want 00", bus.retire_valid); end
        tick();
        clear_inputs();
        n_checks++; if (bus.retire_valid !== 2'b00) begin n_fail++; $display("FAIL ooo_head_blocked got %b want 00", bus.retire_valid); end
        tick();
        set_wb(3'b001, 5'd0, 5'd0, 5'd0);
        n_checks++; if (bus.retire_valid !== 2'b00) begin n_fail++; $display("FAIL ooo_wb0_cycle got %b want 00", bus.retire_valid); end
        tick();
        clear_inputs();
        n_checks++; if (bus.retire_valid !== 2'b11) begin n_fail++; $display("FAIL ooo_retire01 got %b want 11", bus.retire_valid); end
        n_checks++; if (bus.retire_pd_old !== {7'd11, 7'd10}) begin n_fail++; $display("FAIL ooo_pd_old01 got %h want %h", bus.retire_pd_old, {7'd11, 7'd10}); end
        n_checks++; if (bus.retire_pc !== {32'h1004, 32'h1000}) begin n_fail++; $display("FAIL ooo_pc01 got %h want %h", bus.retire_pc, {32'h1004, 32'h1000}); end
        n_checks++; if (bus.retire_has_rd !== 2'b11) begin n_fail++; $display("FAIL ooo_has_rd got %b want 11", bus.retire_has_rd); end
        tick();
        n_checks++; if (bus.retire_valid !== 2'b11 || bus.head !== 5'd2) begin n_fail++; $display("FAIL ooo_retire23 got %b head %0d want 11 head 2", bus.retire_valid, bus.head); end
        n_checks++; if (bus.retire_pd_old !== {7'd13, 7'd12}) begin n_fail++; $display("FAIL ooo_pd_old23 got %h want %h", bus.retire_pd_old, {7'd13, 7'd12}); end
        tick();
        n_checks++; if (bus.count !== 6'd0 || bus.head !== 5'd4 || bus.retire_valid !== 2'b00) begin n_fail++; $display("FAIL ooo_drained got count %0d head %0d rv %b want 0/4/00", bus.count, bus.head, bus.retire_valid); end
        $display("test_ooo_complete: done, %0d failures so far", n_fail);
    endtask

    task automatic test_partial_retire();
        do_reset();
        alloc_n(4);
        set_wb(3'b111, 5'd0, 5'd2, 5'd0);
        tick();
        clear_inputs();
        n_checks++; if (bus.retire_valid !== 2'b01) begin n_fail++; $display("FAIL part_retire got %b want 01", bus.retire_valid); end
        tick();
        n_checks++; if (bus.head !== 5'd1 || bus.count !== 6'd3 || bus.retire_valid !== 2'b00) begin n_fail++; $display("FAIL part_held got head %0d count %0d rv %b want 1/3/00", bus.head, bus.count, bus.retire_valid); end
        set_wb(3'b010, 5'd0, 5'd1, 5'd0);
        tick();
        clear_inputs();
        n_checks++; if (bus.retire_valid !== 2'b11 || bus.retire_pd_old !== {7'd12, 7'd11}) begin n_fail++; $display("FAIL part_release got %b pd %h want 11 pd %h", bus.retire_valid, bus.retire_pd_old, {7'd12, 7'd11}); end
        tick();
        n_checks++; if (bus.head !== 5'd3 || bus.count !== 6'd1 || bus.retire_valid !== 2'b00) begin n_fail++; $display("FAIL part_tail_wait got head %0d count %0d rv %b want 3/1/00", bus.head, bus.count, bus.retire_valid); end
        $display("test_partial_retire: done, %0d failures so far", n_fail);
    endtask

    task automatic test_mispredict();
        do_reset();
        alloc_n(10);
        bus.alloc_valid   = 1'b1;
        bus.br_mispredict = 1'b1;
        bus.br_tag        = 5'd4;
        #1;
        n_checks++; if (bus.alloc_ready !== 1'b0) begin n_fail++; $display("FAIL mp_ready got %0b want 0", bus.alloc_ready); end
        tick();
        clear_inputs();
        n_checks++; if (bus.flush_out !== 1'b1 || bus.flush_tag !== 5'd4) begin n_fail++; $display("FAIL mp_flush got %0b/%0d want 1/4", bus.flush_out, bus.flush_tag); end
        n_checks++; if (bus.alloc_tag !== 5'd5 || bus.count !== 6'd5) begin n_fail++; $display("FAIL mp_tail_count got %0d/%0d want 5/5", bus.alloc_tag, bus.count); end
        set_wb(3'b001, 5'd7, 5'd0, 5'd0);
        tick();
        clear_inputs();
        n_checks++; if (bus.flush_out !== 1'b0) begin n_fail++; $display("FAIL mp_flush_pulse got %0b want 0", bus.flush_out); end
        tick();
        n_checks++; if (bus.count !== 6'd5 || bus.retire_valid !== 2'b00 || bus.alloc_tag !== 5'd5) begin n_fail++; $display("FAIL mp_wb_dead got count %0d rv %b tag %0d want 5/00/5", bus.count, bus.retire_valid, bus.alloc_tag); end
        // Stale mispredict on a squashed tag must be ignored
        bus.br_mispredict = 1'b1;
        bus.br_tag        = 5'd8;
        tick();
        clear_inputs();
        n_checks++; if (bus.flush_out !== 1'b0 || bus.count !== 6'd5 || bus.flush_tag !== 5'd4) begin n_fail++; $display("FAIL mp_invalid_tag got flush %0b count %0d ftag %0d want 0/5/4", bus.flush_out, bus.count, bus.flush_tag); end
        $display("test_mispredict: done, %0d failures so far", n_fail);
    endtask

    task automatic test_wrap();
        logic [4:0] exp_tag;
        do_reset();
        alloc_n(30);
        for (int k = 0; k < 10; k++) begin
            set_wb(3'b111, 5'(3 * k), 5'(3 * k + 1), 5'(3 * k + 2));
            tick();
        end
        clear_inputs();
        for (int k = 0; k < 20; k++) tick();
        n_checks++; if (bus.head !== 5'd30 || bus.count !== 6'd0 || bus.alloc_tag !== 5'd30) begin n_fail++; $display("FAIL wrap_drain got head %0d count %0d tag %0d want 30/0/30", bus.head, bus.count, bus.alloc_tag); end
        exp_tag = 5'd30;
        for (int i = 0; i < 4; i++) begin
            bus.alloc_valid = 1'b1;
            n_checks++; if (bus.alloc_tag !== exp_tag) begin n_fail++; $display("FAIL wrap_tag got %0d want %0d", bus.alloc_tag, exp_tag); end
            exp_tag = exp_tag + 5'd1;
            tick();
        end
        bus.alloc_valid = 1'b0;
        n_checks++; if (bus.count !== 6'd4) begin n_fail++; $display("FAIL wrap_count got %0d want 4", bus.count); end
        bus.br_mispredict = 1'b1;
        bus.br_tag        = 5'd31;
        tick();
        clear_inputs();
        n_checks++; if (bus.alloc_tag !== 5'd0 || bus.count !== 6'd2 || bus.head !== 5'd30) begin n_fail++; $display("FAIL wrap_mp got tail %0d count %0d head %0d want 0/2/30", bus.alloc_tag, bus.count, bus.head); end
        n_checks++; if (bus.flush_out !== 1'b1 || bus.flush_tag !== 5'd31) begin n_fail++; $display("FAIL wrap_flush got %0b/%0d want 1/31", bus.flush_out, bus.flush_tag); end
        $display("test_wrap: done, %0d failures so far", n_fail);
    endtask

    task automatic test_reset_mid_op();
        do_reset();
        alloc_n(6);
        set_wb(3'b111, 5'd1, 5'd2, 5'd3);
        tick();
        set_wb(3'b011, 5'd4, 5'd5, 5'd0);
        tick();
        set_wb(3'b001, 5'd0, 5'd0, 5'd0);
        tick();
        clear_inputs();
        n_checks++; if (bus.retire_valid !== 2'b11 || bus.count !== 6'd6) begin n_fail++; $display("FAIL rmid_ready got rv %b count %0d want 11/6", bus.retire_valid, bus.count); end
        reset = 1'b1;
        #1;
        n_checks++; if (bus.retire_valid !== 2'b00) begin n_fail++; $display("FAIL rmid_no_retire got %b want 00", bus.retire_valid); end
        tick();
        reset = 1'b0;
        n_checks++; if (bus.count !== 6'd0 || bus.head !== 5'd0 || bus.alloc_ready !== 1'b1) begin n_fail++; $display("FAIL rmid_after got count %0d head %0d ready %0b want 0/0/1", bus.count, bus.head, bus.alloc_ready); end
        n_checks++; if (bus.retire_valid !== 2'b00) begin n_fail++; $display("FAIL rmid_empty got %b want 00", bus.retire_valid); end
        $display("test_reset_mid_op: done, %0d failures so far", n_fail);
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        reset    = 1'b1;
        clear_inputs();
        test_reset_and_fill();
        test_ooo_complete();
        test_partial_retire();
        test_mispredict();
        test_wrap();
        test_reset_mid_op();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
